// File: rtl/watch_counter_param.sv
// HH:MM:SS time-of-day counter with programmable prescaler, clamped load, day-wrap pulse.
// Optional minute-resolution alarm is built only when WATCH_ALARM_EN is defined.
module watch_counter_param #(
  parameter int P_COUNT_BIT = 30,
  parameter int P_SEC_BIT   = 6,
  parameter int P_MIN_BIT   = 6,
  parameter int P_HOUR_BIT  = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [P_COUNT_BIT-1:0] freq,
  input  logic                   load,
  input  logic [P_SEC_BIT-1:0]   load_sec,
  input  logic [P_MIN_BIT-1:0]   load_min,
  input  logic [P_HOUR_BIT-1:0]  load_hour,
  input  logic                   alarm_arm,
  input  logic [P_MIN_BIT-1:0]   alarm_min,
  input  logic [P_HOUR_BIT-1:0]  alarm_hour,
  output logic [P_SEC_BIT-1:0]   sec_cnt,
  output logic [P_MIN_BIT-1:0]   min_cnt,
  output logic [P_HOUR_BIT-1:0]  hour_cnt,
  output logic                   tick_1s,
  output logic                   day_wrap,
  output logic                   alarm_fire
);

  localparam logic [P_COUNT_BIT-1:0] CNT_ONE  = P_COUNT_BIT'(1);
  localparam logic [P_SEC_BIT-1:0]   SEC_MAX  = P_SEC_BIT'(59);
  localparam logic [P_MIN_BIT-1:0]   MIN_MAX  = P_MIN_BIT'(59);
  localparam logic [P_HOUR_BIT-1:0]  HOUR_MAX = P_HOUR_BIT'(23);

  function automatic logic [P_SEC_BIT-1:0] clamp_sec(input logic [P_SEC_BIT-1:0] v);
    return (v > SEC_MAX) ? SEC_MAX : v;
  endfunction

  function automatic logic [P_MIN_BIT-1:0] clamp_min(input logic [P_MIN_BIT-1:0] v);
    return (v > MIN_MAX) ? MIN_MAX : v;
  endfunction

  function automatic logic [P_HOUR_BIT-1:0] clamp_hour(input logic [P_HOUR_BIT-1:0] v);
    return (v > HOUR_MAX) ? HOUR_MAX : v;
  endfunction

  logic [P_COUNT_BIT-1:0] pcnt_q, pcnt_d;
  logic [P_SEC_BIT-1:0]   sec_q, sec_d;
  logic [P_MIN_BIT-1:0]   min_q, min_d;
  logic [P_HOUR_BIT-1:0]  hour_q, hour_d;
  logic                   tick_q, tick_d;
  logic                   wrap_q, wrap_d;
  logic                   sec_evt;

  // freq of 0 or 1 must fire every enabled edge; guarding it also avoids freq-1 underflow.
  assign sec_evt = en && ((freq <= CNT_ONE) || (pcnt_q >= (freq - CNT_ONE)));

  always_comb begin
    pcnt_d = pcnt_q;
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (load) begin
      pcnt_d = '0;
      sec_d  = clamp_sec(load_sec);
      min_d  = clamp_min(load_min);
      hour_d = clamp_hour(load_hour);
    end else if (sec_evt) begin
      pcnt_d = '0;
      tick_d = 1'b1;
      if (sec_q >= SEC_MAX) begin
        sec_d = '0;
        if (min_q >= MIN_MAX) begin
          min_d = '0;
          if (hour_q >= HOUR_MAX) begin
            hour_d = '0;
            wrap_d = 1'b1;
          end else begin
            hour_d = hour_q + P_HOUR_BIT'(1);
          end
        end else begin
          min_d = min_q + P_MIN_BIT'(1);
        end
      end else begin
        sec_d = sec_q + P_SEC_BIT'(1);
      end
    end else if (en) begin
      pcnt_d = pcnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pcnt_q <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign sec_cnt  = sec_q;
  assign min_cnt  = min_q;
  assign hour_cnt = hour_q;
  assign tick_1s  = tick_q;
  assign day_wrap = wrap_q;

`ifdef WATCH_ALARM_EN
  logic alarm_q, alarm_d;

  // Match against the post-increment time so the pulse lines up with the new counts.
  always_comb begin
    alarm_d = sec_evt && !load && alarm_arm && (sec_d == '0) &&
              (min_d == alarm_min) && (hour_d == alarm_hour);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign alarm_fire = alarm_q;
`else
  logic unused_alarm_inputs;
  assign unused_alarm_inputs = ^{alarm_arm, alarm_min, alarm_hour};
  assign alarm_fire = 1'b0;
`endif

endmodule

// File: tb/tb_watch_counter_param.sv
// Bench for watch_counter_param: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a seconds-of-day reference model.
module tb_watch_counter_param;

  logic        clk = 1'b0;
  logic        rst, en, load, alarm_arm;
  logic [29:0] freq;
  logic [5:0]  load_sec, load_min, alarm_min;
  logic [4:0]  load_hour, alarm_hour;
  logic [5:0]  sec_cnt, min_cnt;
  logic [4:0]  hour_cnt;
  logic        tick_1s, day_wrap, alarm_fire;

  watch_counter_param dut (
    .clk(clk), .rst(rst), .en(en), .freq(freq), .load(load),
    .load_sec(load_sec), .load_min(load_min), .load_hour(load_hour),
    .alarm_arm(alarm_arm), .alarm_min(alarm_min), .alarm_hour(alarm_hour),
    .sec_cnt(sec_cnt), .min_cnt(min_cnt), .hour_cnt(hour_cnt),
    .tick_1s(tick_1s), .day_wrap(day_wrap), .alarm_fire(alarm_fire)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: time of day as seconds since midnight, prescaler as a plain count.
  int m_tod = 0;
  int m_pc = 0;
  bit m_tick = 0, m_wrap = 0, m_fire = 0;
  int n_ticks = 0, n_fires = 0;

`ifdef WATCH_ALARM_EN
  localparam bit ALARM_BUILT = 1'b1;
`else
  localparam bit ALARM_BUILT = 1'b0;
`endif

  function automatic int clampv(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    m_tick = 0; m_wrap = 0; m_fire = 0;
    if (!rst) begin
      m_tod = 0; m_pc = 0;
    end else if (load) begin
      m_tod = clampv(int'(load_hour), 23) * 3600 + clampv(int'(load_min), 59) * 60
            + clampv(int'(load_sec), 59);
      m_pc = 0;
    end else if (en) begin
      if (m_pc + 1 >= int'(freq)) begin
        m_pc = 0;
        m_tod = (m_tod + 1) % 86400;
        m_tick = 1;
        m_wrap = (m_tod == 0);
        m_fire = ALARM_BUILT && alarm_arm && (alarm_hour < 24) && (alarm_min < 60) &&
                 (m_tod == int'(alarm_hour) * 3600 + int'(alarm_min) * 60);
      end else begin
        m_pc++;
      end
    end
  endtask

  // One clock: model follows the edge, outputs are compared 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("sec_cnt", 32'(sec_cnt), 32'(m_tod % 60));
    chk("min_cnt", 32'(min_cnt), 32'((m_tod / 60) % 60));
    chk("hour_cnt", 32'(hour_cnt), 32'(m_tod / 3600));
    chk("tick_1s", 32'(tick_1s), 32'(m_tick));
    chk("day_wrap", 32'(day_wrap), 32'(m_wrap));
    chk("alarm_fire", 32'(alarm_fire), 32'(m_fire));
    n_ticks += int'(tick_1s);
    n_fires += int'(alarm_fire);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load = 1; load_hour = 5'(h); load_min = 6'(m); load_sec = 6'(s);
    cycle();
    load = 0;
  endtask

  initial begin
    rst = 0; en = 1; load = 1; freq = 30'd10; alarm_arm = 0; alarm_min = 0; alarm_hour = 0;
    load_sec = 6'd7; load_min = 6'd8; load_hour = 5'd9;
    run(2);
    chk("reset_sec", 32'(sec_cnt), 32'd0);
    chk("reset_tick", 32'(tick_1s), 32'd0);

    // 1 Hz from a 10-cycle second
    rst = 1; load = 0; en = 1; freq = 30'd10; n_ticks = 0;
    run(10);
    chk("sec_after_10", 32'(sec_cnt), 32'd1);
    chk("tick_at_10", 32'(tick_1s), 32'd1);
    run(590);
    chk("min_after_600", 32'(min_cnt), 32'd1);
    chk("sec_after_600", 32'(sec_cnt), 32'd0);
    chk("ticks_in_600", 32'(n_ticks), 32'd60);

    // Day wrap
    do_load(23, 59, 58);
    run(10);
    chk("sec_59", 32'(sec_cnt), 32'd59);
    run(10);
    chk("wrap_pulse", 32'(day_wrap), 32'd1);
    chk("wrap_tick", 32'(tick_1s), 32'd1);
    chk("wrap_hour", 32'(hour_cnt), 32'd0);
    run(1);
    chk("wrap_one_cycle", 32'(day_wrap), 32'd0);

    // Clamped load, en high at the same time
    do_load(31, 60, 63);
    chk("clamp_sec", 32'(sec_cnt), 32'd59);
    chk("clamp_min", 32'(min_cnt), 32'd59);
    chk("clamp_hour", 32'(hour_cnt), 32'd23);
    chk("clamp_no_tick", 32'(tick_1s), 32'd0);
    chk("clamp_no_wrap", 32'(day_wrap), 32'd0);

    // Freeze mid-second
    do_load(1, 2, 3);
    run(4);
    en = 0;
    run(37);
    chk("frozen_sec", 32'(sec_cnt), 32'd3);
    en = 1;
    run(5);
    chk("resume_no_tick", 32'(sec_cnt), 32'd3);
    run(1);
    chk("resume_sec", 32'(sec_cnt), 32'd4);
    chk("resume_tick", 32'(tick_1s), 32'd1);

    // Alarm armed, then disarmed
    freq = 30'd4; alarm_hour = 5'd0; alarm_min = 6'd2; alarm_arm = 1;
    do_load(0, 1, 58);
    n_fires = 0;
    run(8);
    chk("alarm_min_now", 32'(min_cnt), 32'd2);
    chk("alarm_with_tick", 32'(alarm_fire), 32'(ALARM_BUILT ? tick_1s : 1'b0));
    run(4);
    chk("alarm_fires_armed", 32'(n_fires), 32'(ALARM_BUILT));
    alarm_arm = 0;
    do_load(0, 1, 58);
    n_fires = 0;
    run(12);
    chk("alarm_fires_disarmed", 32'(n_fires), 32'd0);

    // Reset mid-count, then freq=1
    freq = 30'd10;
    do_load(12, 34, 56);
    run(3);
    rst = 0;
    run(1);
    chk("rst_hour", 32'(hour_cnt), 32'd0);
    chk("rst_min", 32'(min_cnt), 32'd0);
    rst = 1; freq = 30'd1; n_ticks = 0;
    run(10);
    chk("freq1_ticks", 32'(n_ticks), 32'd10);
    chk("freq1_sec", 32'(sec_cnt), 32'd10);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 299) != 0);
      load = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 99) == 0) freq = 30'($urandom_range(0, 6));
      if (load) begin
        if ($urandom_range(0, 1) != 0) begin
          load_hour = 5'($urandom); load_min = 6'($urandom); load_sec = 6'($urandom);
        end else begin
          load_hour = 5'($urandom_range(0, 23)); load_min = 6'($urandom_range(58, 59));
          load_sec = 6'($urandom_range(50, 59));
        end
      end
      alarm_arm = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        alarm_hour = 5'(((m_tod / 60 + 1) % 1440) / 60);
        alarm_min = 6'((m_tod / 60 + 1) % 60);
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/watch_counter_param.md
# watch_counter_param

Parametrised hour/minute/second time-of-day counter with a programmable tick prescaler, synchronous time load, day-wrap indication and an optional minute-resolution alarm. It is the successor to the fixed first-generation watch counter. It sits between the system clock domain and display/alarm logic, and turns a raw clock plus a cycles-per-second value into HH:MM:SS counts.

## Interface
Parameters:
- P_COUNT_BIT, 30 — prescaler/frequency width; 2^30 covers clocks under 1 GHz
- P_SEC_BIT, 6 — seconds width; must be >= 6
- P_MIN_BIT, 6 — minutes width; must be >= 6
- P_HOUR_BIT, 5 — hours width; must be >= 5

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- en  in  1  run enable; prescaler and counters advance only while 1
- freq  in  P_COUNT_BIT  clock cycles per second
- load  in  1  synchronous time load strobe
- load_sec  in  P_SEC_BIT  seconds value for load
- load_min  in  P_MIN_BIT  minutes value for load
- load_hour  in  P_HOUR_BIT  hours value for load
- alarm_arm  in  1  alarm enable level
- alarm_min  in  P_MIN_BIT  alarm minute
- alarm_hour  in  P_HOUR_BIT  alarm hour
- sec_cnt  out  P_SEC_BIT  seconds, 0..59
- min_cnt  out  P_MIN_BIT  minutes, 0..59
- hour_cnt  out  P_HOUR_BIT  hours, 0..23
- tick_1s  out  1  one-cycle pulse per second increment
- day_wrap  out  1  one-cycle pulse on 23:59:59 -> 00:00:00
- alarm_fire  out  1  one-cycle alarm pulse

## Operation
- Priority per edge: reset > load > en-gated counting > hold.
- Prescaler `pcnt`, P_COUNT_BIT wide. While en=1, it increments each edge.
  - At terminal (`pcnt >= freq-1`), it clears to 0 and a second event occurs.
  - freq of 0 or 1 gives a second event on every enabled edge.
  - Comparison is >=, so lowering freq mid-count terminates on the next enabled edge.
- Second event: sec_cnt increments. The cascade runs as sec 59 -> 0 with min++, min 59 -> 0 with hour++, hour 23 -> 0 with a day_wrap pulse.
- en=0: pcnt and all counts hold; no pulses.
- load=1 (regardless of en):
  - sec/min/hour take the load values, clamped: sec > 59 -> 59, min > 59 -> 59, hour > 23 -> 23.
  - pcnt clears to 0.
  - No tick, wrap or alarm pulse is generated from that edge.
- Alarm: on a second event whose result is hour==alarm_hour, min==alarm_min, sec==0 with alarm_arm=1, alarm_fire pulses.
  - Load never fires the alarm.
  - Deasserting alarm_arm suppresses the alarm with no latency.

## Timing
- Reset value: all counts 0, pcnt 0, tick_1s, day_wrap and alarm_fire 0.
- Second event at edge k (en=1 and pcnt >= freq-1 sampled at edge k):
  - The new count values are visible after edge k.
  - tick_1s, and day_wrap/alarm_fire where they apply, are high for exactly the cycle after edge k, aligned with the new counts.
- From the first edge with en=1 and pcnt=0, the first second event is the freq-th enabled edge.
- Load latency: 1 edge. Counts show the clamped values after the load edge, and the next second event is freq enabled edges later.
- Reset mid-count or mid-pulse clears everything on that edge. Any pending pulse is dropped.
- Simultaneous load and en: load wins and pcnt restarts.
- Simultaneous rst=0 and load: reset wins.

## Configuration
- Macro `WATCH_ALARM_EN`.
- Defined: the alarm comparator is built and behaves as described under Operation.
- Undefined:
  - alarm_arm, alarm_min and alarm_hour are present but ignored.
  - alarm_fire is tied to constant 0.
  - No alarm logic is synthesised.
- Port list is identical in both builds.

## Test plan
- freq=10, 10 ns clock, release rst then en=1 -> tick_1s every 100 ns; sec_cnt reads 1 after the 10th enabled edge; 00:01:00 after 600 enabled edges.
- load 23:59:58, freq=10, en=1 -> 23:59:59 after 10 edges; 00:00:00 after 20 edges with day_wrap and tick_1s both high for exactly one cycle.
- load sec=63, min=60, hour=31 -> counts read 59, 59, 23 after one edge; no tick_1s or day_wrap pulse.
- en toggled low for 37 cycles mid-second -> counts and prescaler frozen; the second completes after exactly the remaining enabled edges.
- With `WATCH_ALARM_EN`, alarm 00:02, armed, start from 00:01:58, freq=4:
  - alarm_fire pulses once, coincident with the tick_1s pulse when counts become 00:02:00.
  - Disarmed: no pulse.
  - Without the macro: never pulses.
- rst=0 asserted for one edge mid-count at 12:34:56 -> all outputs 0 next cycle; freq=1 afterwards -> tick_1s high every cycle while en=1.
